// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg
//   Shared definitions for the register-bank dump controller: the FSM state
//   type and the default word/address widths of the register bank.
package reg_dump_pkg;

  // Word width of the register bank.
  localparam int DUMP_W = 16;
  // Address width of the register bank (2**DUMP_N words).
  localparam int DUMP_N = 5;

  // Dump controller states.
  //   IDLE  : waiting for start
  //   FETCH : first read of the range, one cycle
  //   SEND  : presenting a word, prefetching the next one
  //   DONE  : one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage : reg_dump_pkg

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl
//   Sequential reader for the register bank. A start pulse in IDLE latches an
//   address range [first_addr .. last_addr] (modulo 2**N, so a range may wrap
//   through address 0). The controller walks the range through the bank's
//   combinational read port and streams each word, tagged with its address,
//   over a valid/ready interface.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   one-cycle dump request, honoured only in IDLE
//   abort       in   synchronous cancel, honoured only in FETCH and SEND
//   first_addr  in   first address of the dump, latched on accepted start
//   last_addr   in   last address of the dump, latched on accepted start
//   rd_addr     out  bank read address (from registered state only)
//   rd_data     in   bank read data for rd_addr (combinational)
//   out_valid   out  out_data/out_addr/out_last are valid
//   out_ready   in   downstream accepts the current word
//   out_data    out  registered word
//   out_addr    out  address of out_data
//   out_last    out  current word is the final word of the dump
//   busy        out  high in FETCH and SEND
//   done        out  one-cycle pulse after the final word is accepted
//   dbg_state   out  current FSM state, for observation only
//
// Handshake: a word transfers on a rising edge where out_valid and out_ready
// are both high. Once out_valid rises, out_valid and the payload (out_data,
// out_addr, out_last) stay stable until the word transfers or the dump is
// aborted; out_ready may change in any cycle and has no combinational effect
// on any output.
module reg_dump_ctrl
  import reg_dump_pkg::*;
#(
  parameter int W = DUMP_W,
  parameter int N = DUMP_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] first_addr,
  input  logic [N-1:0] last_addr,
  output logic [N-1:0] rd_addr,
  input  logic [W-1:0] rd_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [N-1:0] out_addr,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output dump_state_t  dbg_state
);

  localparam logic [N-1:0] ADDR_ONE = N'(1);

  dump_state_t  state_q, state_d;
  logic [N-1:0] cur_q, cur_d;
  logic [N-1:0] lst_q, lst_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [N-1:0] out_addr_q, out_addr_d;

  // cur tracks the address of the word being presented. While a word is on
  // the output the bank is already reading the following address, so a
  // handshake can capture the next word in the same edge and sustain one
  // word per cycle. N-bit addition wraps naturally from 2**N-1 to 0.
  logic [N-1:0] cur_next;
  logic         at_last;

  assign cur_next = cur_q + ADDR_ONE;
  assign at_last  = (out_addr_q == lst_q);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      lst_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      lst_q      <= lst_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    lst_d      = lst_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cur_d   = first_addr;
          lst_d   = last_addr;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          out_data_d = rd_data;
          out_addr_d = cur_q;
          state_d    = SEND;
        end
      end

      SEND: begin
        // abort wins over a handshake in the same cycle; the presented word
        // is simply dropped.
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (at_last) begin
            state_d = DONE;
          end else begin
            out_data_d = rd_data;
            out_addr_d = out_addr_q + ADDR_ONE;
            cur_d      = cur_next;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only. In SEND the read port is
  // pointed one address ahead so the next word is ready at the handshake.
  assign rd_addr   = (state_q == SEND) ? cur_next : cur_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_valid & at_last;
  assign busy      = (state_q == FETCH) || (state_q == SEND);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule : reg_dump_ctrl

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Sequential reader for the register bank. On a start pulse it walks a programmable address range through one bank read port and streams each word, tagged with its address, out over a valid/ready interface. It is used for debug dumps and context save. It is the read-side counterpart of the bank's write port: it drives the read address and consumes the read data.

## Interface
- W, 16, word width in bits; must match the bank.
- N, 5, address width in bits; the bank holds 2**N words.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  synchronous cancel of an in-progress dump.
- first_addr  in  N  first address of the dump; latched on an accepted start.
- last_addr  in  N  final address of the dump; latched on an accepted start.
- rd_addr  out  N  address driven to the bank read port.
- rd_data  in  W  combinational read data returned by the bank for rd_addr.
- out_valid  out  1  out_data, out_addr and out_last are valid.
- out_ready  in  1  downstream accepts the current word.
- out_data  out  W  registered word.
- out_addr  out  N  address of out_data.
- out_last  out  1  current word is the final word of the dump.
- busy  out  1  high in FETCH and SEND.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- The FSM has four states: IDLE, FETCH, SEND and DONE.
- IDLE, with start=1: latch first_addr into cur and last_addr into lst, then go to FETCH.
- FETCH (exactly 1 cycle):
  - rd_addr=cur.
  - At the clock edge, out_data<=rd_data and out_addr<=cur, then go to SEND.
- SEND:
  - out_valid=1 and rd_addr=cur+1 (modulo 2**N).
  - out_data, out_addr and out_last hold until a handshake (out_valid & out_ready).
- Handshake in SEND, with out_addr!=lst:
  - out_data<=rd_data and out_addr<=out_addr+1, with wrap-around from 2**N-1 to 0.
  - cur advances and the FSM stays in SEND. Throughput is 1 word per cycle.
- Handshake in SEND, with out_addr==lst: go to DONE and drop out_valid.
- DONE (1 cycle): done=1, then go to IDLE. A start in DONE is ignored.
- Address range:
  - Word count is ((lst-first) mod 2**N)+1.
  - first==last sends exactly 1 word.
  - first>last wraps through address 0.
  - first=last+1 dumps all 2**N words.
- out_last = out_valid & (out_addr==lst).
- abort in FETCH or SEND: go to IDLE on the next edge. out_valid drops, a pending word is discarded, and done is not pulsed. abort has priority over a simultaneous handshake. abort is ignored in IDLE and DONE.
- start while busy is ignored. first_addr and last_addr are don't-care outside an accepted start.
- out_data captures the bank contents at the capture edge. A bank write to a word that has not yet been captured is reflected in the dump; a write to a captured word is not.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - rd_addr, out_data, out_addr, cur and lst all 0.
  - out_valid, out_last, busy and done all 0.
- Reset asserted mid-dump ends the dump silently; no done pulse.
- Latency with start accepted at edge 0:
  - FETCH in cycle 1.
  - out_valid=1 from cycle 2.
  - With out_ready tied to 1, word k is presented in cycle 2+k.
  - done is high in cycle 2+count.
- Handshake rules:
  - Once out_valid rises, it and the payload hold stable until accepted or aborted.
  - out_ready may toggle freely, and a cycle without out_ready stalls with no loss.
- rd_addr is registered or derived from registered state only; there is no combinational path from any input to rd_addr.
- Every output is driven from a register or from state decode.

## Structure
- Package reg_dump_pkg:
  - typedef enum logic [1:0] dump_state_t {IDLE, FETCH, SEND, DONE}.
  - Defaults for W and N.
- A single module with no sub-module. The address incrementer is inline modulo-2**N arithmetic, with an N-bit wrap and no carry out.
- The bench instantiates reg_dump_ctrl with the team's register bank. The bank's active-low reset is driven by the inverted reset.

## Test plan
- Full-range wrap: preload the bank with bank[i]=16'hA000+i. Drive first=0, last=31 with out_ready=1.
  - Required: 32 words A000..A01F in consecutive cycles 2..33.
  - Required: out_last only with addr 31, and done in cycle 34.
- Wrap-around: first=30, last=1.
  - Required: 4 words, addresses 30, 31, 0, 1 in order, with data A01E, A01F, A000, A001.
- Backpressure: drive out_ready with a random 50% duty cycle over first=4, last=9.
  - Required: payload stable while stalled, no duplicated or dropped words, 6 words total.
- Single word and full dump:
  - first=last=7: exactly 1 word A007 with out_last=1.
  - first=8, last=7: all 32 words starting at address 8.
- Abort: assert abort in the cycle of the 3rd handshake.
  - Required: IDLE next cycle, out_valid=0, no done pulse.
  - Required: a new start is accepted on the following cycle.
- Async reset and ignored start: assert reset mid-SEND.
  - Required: all outputs are 0 immediately, before the next edge.
  - Required: a start pulse during a dump or in DONE has no effect on the running sequence.
